pll_lock_sequencer: RTL and testbench

Reset and lock sequencer that sits directly upstream and downstream of the system PLL, in the 50 MHz reference-clock domain. It drives the PLL's active-high reset input and consumes the PLL's asynchronous `locked` output. It holds the memory-test core in reset until lock has been stable for a programmable time. It re-sequences on loss of lock, and retries a bounded number of times before latching a failure.

---
 rtl/pll_lock_sequencer.sv | 145 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL reset pulse, lock qualification and retry sequencing for the refclk domain.
// Holds the downstream core in reset until PLL lock has been stable long enough.
module pll_lock_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       core_rst_n,
  output logic       fail,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count
);

  localparam int MAX_AB =
    (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
    RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAXP =
    (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
    MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXP + 1);

  localparam logic [CW-1:0] PULSE_LAST  =
    CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST    =
    CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX   =
    4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    retry_n;
  logic [7:0]    loss_n;
  logic          sync_q, locked_s;

  // locked is asynchronous to refclk; only locked_s is used below.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync_q   <= locked;
      locked_s <= sync_q;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    retry_n = retry_count;
    loss_n  = lock_loss_count;
    if (soft_reset) begin
      state_n = S_PLL_RST;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      unique case (state)
        S_PLL_RST: begin
          if (cnt == PULSE_LAST) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_n = S_STABLE;
            cnt_n   = '0;
          end else if (cnt == TMO_LAST) begin
            cnt_n = '0;
            if (retry_count == RETRY_MAX) begin
              state_n = S_FAIL;
            end else begin
              state_n = S_PLL_RST;
              retry_n = retry_count + 4'd1;
            end
          end
        end
        S_STABLE: begin
          if (!locked_s) begin
            state_n = S_WAIT_LOCK;
            cnt_n   = '0;
          end else if (cnt == STABLE_LAST) begin
            state_n = S_RUN;
            cnt_n   = '0;
            retry_n = '0;
          end
        end
        S_RUN: begin
          cnt_n = '0;
          if (!locked_s) begin
            state_n = S_PLL_RST;
            if (lock_loss_count != 8'hff) begin
              loss_n = lock_loss_count + 8'd1;
            end
          end
        end
        S_FAIL: begin
          cnt_n = '0;
        end
        default: begin
          state_n = S_PLL_RST;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs decode state_n so they switch on the same edge as the state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_PLL_RST;
      cnt             <= '0;
      pll_rst         <= 1'b1;
      core_rst_n      <= 1'b0;
      fail            <= 1'b0;
      retry_count     <= '0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      retry_count     <= retry_n;
      lock_loss_count <= loss_n;
      pll_rst         <= (state_n == S_PLL_RST) ||
                         (state_n == S_FAIL);
      core_rst_n      <= (state_n == S_RUN);
      fail            <= (state_n == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: bring-up, glitch, lock loss,
// retry exhaustion, soft_reset priority and asynchronous reset.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int LS = 8;
  localparam int LT = 32;
  localparam int MR = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst;
  logic       core_rst_n;
  logic       fail;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;

  int checks = 0;
  int failures = 0;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES(RP),
    .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT_CYCLES(LT),
    .MAX_RETRIES(MR)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .locked(locked),
    .soft_reset(soft_reset),
    .pll_rst(pll_rst),
    .core_rst_n(core_rst_n),
    .fail(fail),
    .retry_count(retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #10 refclk = ~refclk;

  // retry scenario table: edge index -> {pll_rst, fail, retry_count}
  int         rt_e[9] = '{35, 36, 39, 40, 72, 76, 107, 108, 130};
  logic [5:0] rt_x[9] = '{6'b0_0_0000, 6'b1_0_0001, 6'b1_0_0001,
                          6'b0_0_0001, 6'b1_0_0010, 6'b0_0_0010,
                          6'b0_0_0010, 6'b1_1_0010, 6'b1_1_0010};

  task automatic step();
    @(posedge refclk);
    #1;
  endtask

  // Edge of release is edge 0; first counted edge follows.
  task automatic do_reset();
    rst_n = 1'b0;
    soft_reset = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic wait_core(input logic lvl, input int lim,
                           output int n);
    n = 0;
    while (core_rst_n !== lvl && n <= lim) begin
      step();
      n++;
    end
    if (core_rst_n !== lvl) n = -1;
  endtask

  task automatic wait_pll(input logic lvl, input int lim,
                          output int n);
    n = 0;
    while (pll_rst !== lvl && n <= lim) begin
      step();
      n++;
    end
    if (pll_rst !== lvl) n = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    locked = 1'b0;
    repeat (2) step();
    checks++;
    if (pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL rst_pll_rst got=%b exp=1", pll_rst);
    end
    checks++;
    if (core_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL rst_core_rst_n got=%b exp=0", core_rst_n);
    end
    checks++;
    if (fail !== 1'b0) begin
      failures++;
      $display("FAIL rst_fail got=%b exp=0", fail);
    end
    checks++;
    if ({retry_count, lock_loss_count} !== 12'h000) begin
      failures++;
      $display("FAIL rst_counts got=%h/%h exp=0/00",
               retry_count, lock_loss_count);
    end
  endtask

  task automatic test_bring_up();
    int fall_e;
    int n;
    locked = 1'b0;
    do_reset();
    fall_e = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (fall_e == 0 && pll_rst === 1'b0) fall_e = e;
    end
    checks++;
    if (fall_e !== RP) begin
      failures++;
      $display("FAIL bring_pll_width got=%0d exp=%0d", fall_e, RP);
    end
    locked = 1'b1;
    wait_core(1'b1, 40, n);
    checks++;
    if (n !== 11) begin
      failures++;
      $display("FAIL bring_latency got=%0d exp=11", n);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      failures++;
      $display("FAIL bring_retry got=%0d exp=0", retry_count);
    end
  endtask

  task automatic test_glitch();
    int hi;
    int rise;
    locked = 1'b0;
    do_reset();
    hi = 0;
    rise = 0;
    for (int e = 1; e <= 35; e++) begin
      step();
      if (e >= RP && pll_rst === 1'b1) hi++;
      if (rise == 0 && core_rst_n === 1'b1) rise = e;
      if (e == 10) locked = 1'b1;
      if (e == 15) locked = 1'b0;
      if (e == 18) locked = 1'b1;
    end
    checks++;
    if (hi !== 0) begin
      failures++;
      $display("FAIL glitch_pll_pulse got=%0d exp=0", hi);
    end
    checks++;
    if (rise !== 29) begin
      failures++;
      $display("FAIL glitch_release_edge got=%0d exp=29", rise);
    end
    checks++;
    if (retry_count !== 4'd0) begin
      failures++;
      $display("FAIL glitch_retry got=%0d exp=0", retry_count);
    end
  endtask

  task automatic test_lock_loss();
    int n;
    int tmo;
    locked = 1'b1;
    do_reset();
    wait_core(1'b1, 40, n);
    locked = 1'b0;
    wait_core(1'b0, 10, n);
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL loss_core_latency got=%0d exp=3", n);
    end
    checks++;
    if (pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL loss_pll_rise got=%b exp=1", pll_rst);
    end
    wait_pll(1'b0, 10, n);
    checks++;
    if (n !== RP) begin
      failures++;
      $display("FAIL loss_pll_width got=%0d exp=%0d", n, RP);
    end
    checks++;
    if (lock_loss_count !== 8'd1) begin
      failures++;
      $display("FAIL loss_count1 got=%0d exp=1", lock_loss_count);
    end
    tmo = 0;
    for (int i = 2; i <= 300; i++) begin
      locked = 1'b1;
      wait_core(1'b1, 60, n);
      if (n < 0) tmo++;
      locked = 1'b0;
      wait_core(1'b0, 10, n);
      if (n < 0) tmo++;
    end
    checks++;
    if (tmo !== 0) begin
      failures++;
      $display("FAIL loss_loop_timeouts got=%0d exp=0", tmo);
    end
    checks++;
    if (lock_loss_count !== 8'd255) begin
      failures++;
      $display("FAIL loss_saturate got=%0d exp=255", lock_loss_count);
    end
  endtask

  task automatic test_retry();
    locked = 1'b0;
    do_reset();
    for (int e = 1; e <= 130; e++) begin
      step();
      for (int k = 0; k < 9; k++) begin
        if (rt_e[k] == e) begin
          checks++;
          if ({pll_rst, fail, retry_count} !== rt_x[k]) begin
            failures++;
            $display("FAIL retry_e%0d got=%b exp=%b", e,
                     {pll_rst, fail, retry_count}, rt_x[k]);
          end
        end
      end
    end
    checks++;
    if (core_rst_n !== 1'b0) begin
      failures++;
      $display("FAIL retry_core got=%b exp=0", core_rst_n);
    end
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    checks++;
    if ({pll_rst, fail, retry_count} !== 6'b1_0_0000) begin
      failures++;
      $display("FAIL soft_clear got=%b exp=100000",
               {pll_rst, fail, retry_count});
    end
    repeat (RP - 1) step();
    checks++;
    if (pll_rst !== 1'b1) begin
      failures++;
      $display("FAIL soft_pulse_hi got=%b exp=1", pll_rst);
    end
    step();
    checks++;
    if (pll_rst !== 1'b0) begin
      failures++;
      $display("FAIL soft_pulse_end got=%b exp=0", pll_rst);
    end
  endtask

  task automatic test_priority_async();
    int n;
    locked = 1'b1;
    do_reset();
    wait_core(1'b1, 40, n);
    locked = 1'b0;
    wait_core(1'b0, 10, n);
    locked = 1'b1;
    wait_core(1'b1, 60, n);
    checks++;
    if (n < 0 || lock_loss_count !== 8'd1) begin
      failures++;
      $display("FAIL prio_setup got=%0d/%0d exp=1", n, lock_loss_count);
    end
    locked = 1'b0;
    repeat (2) step();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    locked = 1'b1;
    checks++;
    if ({pll_rst, core_rst_n, lock_loss_count} !== 10'b10_0000_0001) begin
      failures++;
      $display("FAIL prio_soft got=%b/%b/%0d exp=1/0/1",
               pll_rst, core_rst_n, lock_loss_count);
    end
    wait_pll(1'b0, 10, n);
    checks++;
    if (n !== RP) begin
      failures++;
      $display("FAIL prio_pll_width got=%0d exp=%0d", n, RP);
    end
    repeat (3) step();
    checks++;
    if ({pll_rst, core_rst_n, lock_loss_count} !== 10'b00_0000_0001) begin
      failures++;
      $display("FAIL prio_stable got=%b/%b/%0d exp=0/0/1",
               pll_rst, core_rst_n, lock_loss_count);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({pll_rst, core_rst_n, fail} !== 3'b100) begin
      failures++;
      $display("FAIL async_outs got=%b exp=100",
               {pll_rst, core_rst_n, fail});
    end
    checks++;
    if ({retry_count, lock_loss_count} !== 12'h000) begin
      failures++;
      $display("FAIL async_counts got=%h/%h exp=0/00",
               retry_count, lock_loss_count);
    end
  endtask

  initial begin
    test_reset();
    test_bring_up();
    test_glitch();
    test_lock_loss();
    test_retry();
    test_priority_async();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
